// File: rtl/ddmtd_loop_nco.sv
// DDMTD loop return path: PI loop filter on detector phase error, driving a
// phase-accumulator NCO whose registered MSB is the regenerated feedback clock.
module ddmtd_loop_nco #(
   parameter int               ACC_W    = 24,
   parameter logic [ACC_W-1:0] FTW_NOM  = 'h100000,
   parameter int               KP_SHIFT = 4,
   parameter int               KI_SHIFT = 8,
   parameter int               INT_LIM  = 2**20,
   parameter int               LOCK_THR = 64,
   parameter int               LOCK_CNT = 16
) (
   input  logic                    clk_sys,
   input  logic                    rst_n,
   input  logic                    phase_valid,
   input  logic signed [17:0]      phase_err,
   input  logic                    hold,
   output logic                    clk_fb_out,
   output logic        [ACC_W-1:0] ftw,
   output logic                    ftw_valid,
   output logic                    locked
);

   localparam int                 CNT_W      = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]   LOCK_MAX   = CNT_W'(LOCK_CNT);
   localparam logic [31:0]        LOCK_THR_W = 32'(LOCK_THR);
   localparam logic signed [32:0] INT_HI     = 33'(INT_LIM);
   localparam logic signed [32:0] INT_LO     = -INT_HI;
   localparam logic signed [33:0] FTW_MAX    = (34'sd1 <<< (ACC_W - 1)) - 34'sd1;

   function automatic logic signed [31:0] sat_integ(input logic signed [32:0] s);
      if (s > INT_HI)      return INT_HI[31:0];
      else if (s < INT_LO) return INT_LO[31:0];
      else                 return s[31:0];
   endfunction

   // Lower bound 1 keeps the NCO running; upper bound keeps clk_fb_out <= f_clk_sys/2.
   function automatic logic [ACC_W-1:0] sat_ftw(input logic signed [33:0] s);
      if (s < 34'sd1)        return ACC_W'(1);
      else if (s > FTW_MAX)  return FTW_MAX[ACC_W-1:0];
      else                   return s[ACC_W-1:0];
   endfunction

   logic signed [31:0] e;
   logic        [31:0] e_abs;
   logic               in_lock;
   logic signed [32:0] integ_sum;
   logic signed [31:0] integ_sh;
   logic signed [33:0] ftw_sum;

   logic signed [31:0] p_q, p_d;
   logic signed [31:0] integ_q, integ_d;
   logic   [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic               locked_q, locked_d;
   logic               vld_p1_q, vld_p1_d;
   logic   [ACC_W-1:0] ftw_q, ftw_d;
   logic               ftw_valid_q, ftw_valid_d;
   logic   [ACC_W-1:0] acc_q, acc_d;
   logic               clk_fb_q, clk_fb_d;

   always_comb begin
      e         = {{14{phase_err[17]}}, phase_err};
      e_abs     = e[31] ? -e : e;
      in_lock   = (e_abs <= LOCK_THR_W);
      integ_sum = {integ_q[31], integ_q} + {e[31], e};

      p_d        = p_q;
      integ_d    = integ_q;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_q;
      vld_p1_d   = phase_valid;

      // Stage 1: proportional term, integrator and lock qualification
      if (phase_valid) begin
         p_d = hold ? 32'sd0 : (e <<< KP_SHIFT);
         if (!hold) integ_d = sat_integ(integ_sum);
         if (in_lock) lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
         else         lock_cnt_d = '0;
         locked_d = (lock_cnt_d == LOCK_MAX);
      end

      // Stage 2: tuning word from the registers written by stage 1
      integ_sh    = integ_q >>> KI_SHIFT;
      ftw_sum     = {{(34-ACC_W){1'b0}}, FTW_NOM} + {{2{p_q[31]}}, p_q}
                  + {{2{integ_sh[31]}}, integ_sh};
      ftw_d       = vld_p1_q ? sat_ftw(ftw_sum) : ftw_q;
      ftw_valid_d = vld_p1_q;

      acc_d    = acc_q + ftw_q;
      clk_fb_d = acc_q[ACC_W-1];
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         p_q         <= '0;
         integ_q     <= '0;
         lock_cnt_q  <= '0;
         locked_q    <= 1'b0;
         vld_p1_q    <= 1'b0;
         ftw_q       <= FTW_NOM;
         ftw_valid_q <= 1'b0;
         acc_q       <= '0;
         clk_fb_q    <= 1'b0;
      end else begin
         p_q         <= p_d;
         integ_q     <= integ_d;
         lock_cnt_q  <= lock_cnt_d;
         locked_q    <= locked_d;
         vld_p1_q    <= vld_p1_d;
         ftw_q       <= ftw_d;
         ftw_valid_q <= ftw_valid_d;
         acc_q       <= acc_d;
         clk_fb_q    <= clk_fb_d;
      end
   end

   assign clk_fb_out = clk_fb_q;
   assign ftw        = ftw_q;
   assign ftw_valid  = ftw_valid_q;
   assign locked     = locked_q;

endmodule
